pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 45 ++++
 rtl/pong_paddle_mover.sv | 48 ++++
 rtl/pong_game_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared widths, field geometry, game-state encoding and small helpers for the pong controller.
package pong_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CMP_W   = 11;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned SPD_W   = 3;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned FIELD_TOP   = 20;
  localparam int unsigned FIELD_BOT   = 420;
  localparam int unsigned FIELD_LEFT  = 20;
  localparam int unsigned FIELD_RIGHT = 620;
  localparam int unsigned LPAD_FACE   = 43;
  localparam int unsigned RPAD_FACE   = 597;
  localparam int unsigned PAD_HALF    = 25;
  localparam int unsigned BALL_R      = 4;
  localparam int unsigned CENTER_X    = 320;
  localparam int unsigned CENTER_Y    = 220;

  // Derived limits: paddle travel keeps the paddle one row inside the border.
  localparam int unsigned PAD_RESET = 220;
  localparam int unsigned PAD_MIN   = FIELD_TOP + PAD_HALF + 1;
  localparam int unsigned PAD_MAX   = FIELD_BOT - PAD_HALF - 1;
  localparam int unsigned HIT_TOL   = PAD_HALF + BALL_R;
  localparam int unsigned SCORE_MAX = 9;
  localparam int unsigned SPEED_MAX = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY     = 3'd2;
  localparam logic [STATE_W-1:0] ST_SCORED   = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAMEOVER = 3'd4;

  // |a - b| <= HIT_TOL without any subtraction.
  function automatic logic within_tol(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (CMP_W'(a) <= CMP_W'(b) + CMP_W'(HIT_TOL)) &&
           (CMP_W'(b) <= CMP_W'(a) + CMP_W'(HIT_TOL));
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_paddle_mover.sv
// One paddle centre register: steps by PADDLE_SPEED on tick, clamps to the field, reloads on restart.
module pong_paddle_mover
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_SPEED = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               load_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [COORD_W-1:0] center_o
);

  logic [COORD_W-1:0] center_q;
  logic [COORD_W-1:0] center_d;

  always_comb begin
    center_d = center_q;
    if (load_i) begin
      center_d = COORD_W'(PAD_RESET);
    end else if (tick_i && up_i && !down_i) begin
      if (CMP_W'(center_q) < CMP_W'(PAD_MIN) + CMP_W'(PADDLE_SPEED)) begin
        center_d = COORD_W'(PAD_MIN);
      end else begin
        center_d = center_q - COORD_W'(PADDLE_SPEED);
      end
    end else if (tick_i && down_i && !up_i) begin
      if (CMP_W'(center_q) + CMP_W'(PADDLE_SPEED) > CMP_W'(PAD_MAX)) begin
        center_d = COORD_W'(PAD_MAX);
      end else begin
        center_d = center_q + COORD_W'(PADDLE_SPEED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center_q <= COORD_W'(PAD_RESET);
    end else begin
      center_q <= center_d;
    end
  end

  assign center_o = center_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: paddles, ball motion/bounces, goals, scores and IDLE/SERVE/PLAY/GAMEOVER.
// Optional feature macro: PONG_SPEEDUP_EN (ball speeds up on each paddle hit).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SPEED   = 1,
  parameter int unsigned PADDLE_SPEED = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               left_up,
  input  logic               left_down,
  input  logic               right_up,
  input  logic               right_down,
  output logic [COORD_W-1:0] leftPaddle,
  output logic [COORD_W-1:0] rightPaddle,
  output logic [SCORE_W-1:0] scoreLeft,
  output logic [SCORE_W-1:0] scoreRight,
  output logic [COORD_W-1:0] ball_center_x,
  output logic [COORD_W-1:0] ball_center_y,
  output logic               game_over
);

  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [SPD_W-1:0]   spd_q, spd_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic               go_q, go_d;

  logic [CMP_W-1:0]   x_w, y_w, spd_w;
  logic [COORD_W-1:0] spd_c;
  logic               lhit, rhit;
  logic               pad_tick, pad_load;

  function automatic logic [SPD_W-1:0] hit_speed(input logic [SPD_W-1:0] s);
`ifdef PONG_SPEEDUP_EN
    return (s >= SPD_W'(SPEED_MAX)) ? s : s + SPD_W'(1);
`else
    return s;
`endif
  endfunction

  assign x_w   = CMP_W'(x_q);
  assign y_w   = CMP_W'(y_q);
  assign spd_w = CMP_W'(spd_q);
  assign spd_c = COORD_W'(spd_q);

  // Paddle hits only count when the ball crosses the face on this step, not after it passed.
  assign lhit = !dx_q && (x_w > CMP_W'(LPAD_FACE + BALL_R)) &&
                (x_w <= CMP_W'(LPAD_FACE + BALL_R) + spd_w) && within_tol(y_q, leftPaddle);
  assign rhit = dx_q && (x_w < CMP_W'(RPAD_FACE - BALL_R)) &&
                (x_w + spd_w + CMP_W'(BALL_R) >= CMP_W'(RPAD_FACE)) && within_tol(y_q, rightPaddle);

  assign pad_tick = frame_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
  assign pad_load = frame_tick && (state_q == ST_GAMEOVER) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    spd_d   = spd_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          x_d = COORD_W'(CENTER_X);
          y_d = COORD_W'(CENTER_Y);
          if (start) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end
        end
        ST_SERVE: begin
          x_d = COORD_W'(CENTER_X);
          y_d = COORD_W'(CENTER_Y);
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            spd_d   = SPD_W'(BALL_SPEED);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (dy_q) begin
            if (y_w + spd_w + CMP_W'(BALL_R) >= CMP_W'(FIELD_BOT)) begin
              y_d  = COORD_W'(FIELD_BOT - BALL_R - 1);
              dy_d = 1'b0;
            end else begin
              y_d = y_q + spd_c;
            end
          end else begin
            if (y_w <= CMP_W'(FIELD_TOP + BALL_R) + spd_w) begin
              y_d  = COORD_W'(FIELD_TOP + BALL_R + 1);
              dy_d = 1'b1;
            end else begin
              y_d = y_q - spd_c;
            end
          end
          if (lhit) begin
            x_d   = COORD_W'(LPAD_FACE + BALL_R + 1);
            dx_d  = 1'b1;
            spd_d = hit_speed(spd_q);
          end else if (rhit) begin
            x_d   = COORD_W'(RPAD_FACE - BALL_R - 1);
            dx_d  = 1'b0;
            spd_d = hit_speed(spd_q);
          end else if (!dx_q) begin
            x_d = x_q - spd_c;
            if (x_w <= CMP_W'(FIELD_LEFT + BALL_R) + spd_w) begin
              sr_d    = score_inc(sr_q);
              state_d = ST_SCORED;
            end
          end else begin
            x_d = x_q + spd_c;
            if (x_w + spd_w + CMP_W'(BALL_R) >= CMP_W'(FIELD_RIGHT)) begin
              sl_d    = score_inc(sl_q);
              state_d = ST_SCORED;
            end
          end
        end
        ST_SCORED: begin
          // dx is left untouched: on a miss it already points at the conceding side.
          x_d = COORD_W'(CENTER_X);
          y_d = COORD_W'(CENTER_Y);
          if ((sl_q == SCORE_W'(WIN_SCORE)) || (sr_q == SCORE_W'(WIN_SCORE))) begin
            state_d = ST_GAMEOVER;
          end else begin
            spd_d   = SPD_W'(BALL_SPEED);
            cnt_d   = '0;
            state_d = ST_SERVE;
          end
        end
        ST_GAMEOVER: begin
          x_d = COORD_W'(CENTER_X);
          y_d = COORD_W'(CENTER_Y);
          if (start) begin
            sl_d    = '0;
            sr_d    = '0;
            spd_d   = SPD_W'(BALL_SPEED);
            cnt_d   = '0;
            state_d = ST_SERVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    go_d = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= COORD_W'(CENTER_X);
      y_q     <= COORD_W'(CENTER_Y);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      spd_q   <= SPD_W'(BALL_SPEED);
      sl_q    <= '0;
      sr_q    <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      spd_q   <= spd_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      go_q    <= go_d;
    end
  end

  pong_paddle_mover #(.PADDLE_SPEED(PADDLE_SPEED)) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (pad_tick),
    .load_i   (pad_load),
    .up_i     (left_up),
    .down_i   (left_down),
    .center_o (leftPaddle)
  );

  pong_paddle_mover #(.PADDLE_SPEED(PADDLE_SPEED)) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (pad_tick),
    .load_i   (pad_load),
    .up_i     (right_up),
    .down_i   (right_down),
    .center_o (rightPaddle)
  );

  assign ball_center_x = x_q;
  assign ball_center_y = y_q;
  assign scoreLeft     = sl_q;
  assign scoreRight    = sr_q;
  assign game_over     = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table for idle/serve, hand sequences for play corners.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, left_up, left_down, right_up, right_down;
  logic [9:0] leftPaddle, rightPaddle, ball_center_x, ball_center_y;
  logic [3:0] scoreLeft, scoreRight;
  logic       game_over;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .left_up       (left_up),
    .left_down     (left_down),
    .right_up      (right_up),
    .right_down    (right_down),
    .leftPaddle    (leftPaddle),
    .rightPaddle   (rightPaddle),
    .scoreLeft     (scoreLeft),
    .scoreRight    (scoreRight),
    .ball_center_x (ball_center_x),
    .ball_center_y (ball_center_y),
    .game_over     (game_over)
  );

  typedef struct {
    logic s, lu, ld, ru, rd;
    int   lp, rp, bx, by, sl, sr, go;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic s, input logic lu, input logic ld, input logic ru,
                              input logic rd, input int lp, input int rp, input int bx,
                              input int by, input int sl, input int sr, input int go);
    vec_t v;
    v.s = s; v.lu = lu; v.ld = ld; v.ru = ru; v.rd = rd;
    v.lp = lp; v.rp = rp; v.bx = bx; v.by = by; v.sl = sl; v.sr = sr; v.go = go;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int lp, input int rp, input int bx,
                         input int by, input int sl, input int sr, input int go);
    chk({name, " lp"}, int'(leftPaddle), lp);
    chk({name, " rp"}, int'(rightPaddle), rp);
    chk({name, " bx"}, int'(ball_center_x), bx);
    chk({name, " by"}, int'(ball_center_y), by);
    chk({name, " sl"}, int'(scoreLeft), sl);
    chk({name, " sr"}, int'(scoreRight), sr);
    chk({name, " go"}, int'(game_over), go);
  endtask

  task automatic chk_ball(input string name, input int bx, input int by);
    chk({name, " bx"}, int'(ball_center_x), bx);
    chk({name, " by"}, int'(ball_center_y), by);
  endtask

  // One frame: drive levels, pulse frame_tick for one clk, idle a few clks, sample #1 after an edge.
  task automatic tick(input logic s, input logic lu, input logic ld, input logic ru, input logic rd);
    start = s; left_up = lu; left_down = ld; right_up = ru; right_down = rd;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic s, input logic lu, input logic ld,
                     input logic ru, input logic rd);
    for (int i = 0; i < n; i++) tick(s, lu, ld, ru, rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
    left_up = 1'b0; left_down = 1'b0; right_up = 1'b0; right_down = 1'b0;

    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 220, 220, 320, 220, 0, 0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 220, 220, 320, 220, 0, 0, 0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 220, 220, 320, 220, 0, 0, 0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 220, 220, 320, 220, 0, 0, 0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 220, 220, 320, 220, 0, 0, 0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 220, 220, 320, 220, 0, 0, 0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 218, 220, 320, 220, 0, 0, 0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 220, 220, 320, 220, 0, 0, 0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 220, 220, 320, 220, 0, 0, 0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 220, 222, 320, 220, 0, 0, 0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 220, 222, 320, 220, 0, 0, 0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 220, 220, 320, 220, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 220, 220, 320, 220, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Game 1: idle freeze, serve, paddle clamps, bounces, right hit, left hit at the tolerance edge.
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].s, vecs[i].lu, vecs[i].ld, vecs[i].ru, vecs[i].rd);
      chk_all($sformatf("vec%0d", i), vecs[i].lp, vecs[i].rp, vecs[i].bx, vecs[i].by,
              vecs[i].sl, vecs[i].sr, vecs[i].go);
    end
    run(54, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("serve_end", 220, 328, 320, 220, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("play_k1", 321, 221);
    run(50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lp_up50", int'(leftPaddle), 120);
    chk_ball("play_k51", 371, 271);
    run(50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lp_clamp", int'(leftPaddle), 46);
    run(10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lp_both", int'(leftPaddle), 46);
    run(82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k193", 513, 413);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("k194 by", int'(ball_center_y), 414);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("k195 by", int'(ball_center_y), 415);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bot_bounce by", int'(ball_center_y), 415);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k197", 517, 414);
    run(75, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k272", 592, 339);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("rhit", 592, 338);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("after_rhit", 591, 337);
    run(90, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lp_down90", int'(leftPaddle), 226);
    chk("k364 bx", int'(ball_center_x), 501);
    run(222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k586", 279, 25);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("top_bounce by", int'(ball_center_y), 25);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k588", 277, 26);
    run(229, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("k817", 48, 255);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("lhit", 48, 256);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("after_lhit", 49, 257);
    chk("g1 sr", int'(scoreRight), 0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 220, 220, 320, 220, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Game 2: same rally but left paddle off by 35 rows, so the ball scores on the left.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(54, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(817, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("g2 k817", 48, 255);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lmiss bx", int'(ball_center_x), 47);
    run(22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("g2 k840 bx", int'(ball_center_x), 25);
    chk("g2 k840 sr", int'(scoreRight), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lgoal sr", int'(scoreRight), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("scored", 220, 328, 320, 220, 0, 1, 0);
    run(60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("g2 serve", 320, 220);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("serve_left", 319, 221);

    // Game 3: nine unanswered left-player goals, game over, restart.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int g = 1; g <= 9; g++) begin
      if (g == 9) begin
        run(5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(290, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        run(295, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("r%0d pre bx", g), int'(ball_center_x), 615);
      chk($sformatf("r%0d pre sl", g), int'(scoreLeft), g - 1);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("r%0d goal sl", g), int'(scoreLeft), g);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("r%0d go", g), int'(game_over), (g == 9) ? 1 : 0);
      chk_ball($sformatf("r%0d centre", g), 320, 220);
      if (g < 9) run(60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("gameover_hold", 210, 220, 320, 220, 9, 0, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("restart", 220, 220, 320, 220, 0, 0, 0);
    run(60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("restart serve", 320, 220);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ball("restart play", 321, 219);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
